// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared state encoding, default sizes and counter width helper
package uart_ctrl_pkg;
    localparam int NUM_REQ_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;
    function automatic int cnt_w(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction
    localparam int CNT_W = cnt_w(TIMEOUT_CYCLES_DEF);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic          found;
    logic [IW-1:0] sel;
    // first asserted request at or after ptr wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            sel = IW'((int'(ptr) + k) % N);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet-locking arbiter feeding one UART transmitter
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int  NUM_REQ        = NUM_REQ_DEF,
    parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int IW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW             = cnt_w(TIMEOUT_CYCLES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_send,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_done,
    output logic [IW-1:0]        owner,
    output logic                 busy,
    output logic                 timeout_err
);
    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, owner_q, owner_d, gidx, nxt_ptr;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d, terr_q, terr_d, tmo;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gidx)
    );

    assign nxt_ptr      = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign tmo          = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign uart_send    = state_q == SEND;
    assign uart_tx_data = data_q;
    assign owner        = owner_q;
    assign busy         = state_q != IDLE;
    assign timeout_err  = terr_q;

    // next state, handshake and lock release; done beats timeout in WAIT
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        data_d    = data_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        terr_d    = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|req_valid) begin
                    owner_d = gidx;
                    data_d  = req_data[{gidx, 3'b000} +: 8];
                    last_d  = req_last[gidx];
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (uart_tx_done) begin
                    cnt_d   = '0;
                    state_d = last_q ? IDLE : HOLD;
                    ptr_d   = last_q ? nxt_ptr : ptr_q;
                end else if (tmo) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end
            end
            HOLD: begin
                req_ready[owner_q] = req_valid[owner_q];
                cnt_d = cnt_q + 1'b1;
                if (req_valid[owner_q]) begin
                    data_d  = req_data[{owner_q, 3'b000} +: 8];
                    last_d  = req_last[owner_q];
                    state_d = SEND;
                end else if (tmo) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end
            end
        endcase
    end

    // state, latches and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end
endmodule
